// File: rtl/ysyx_wbu.sv
// ysyx_wbu: write-back / retire stage.
// Holds finished instructions from execute in a small circular queue and
// retires at most one per cycle, driving the register-file write port, the
// next-PC redirect and the retire trace. An ebreak halts until reset.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

module ysyx_wbu #(
    parameter int BIT_W = `YSYX_W_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prev_valid,
    output logic             ready_o,
    input  logic [31:0]      inst_i,
    input  logic [BIT_W-1:0] pc_i,
    input  logic [BIT_W-1:0] reg_wdata_i,
    input  logic [BIT_W-1:0] npc_wdata_i,
    input  logic             use_exu_npc_i,
    input  logic             branch_retire_i,
    input  logic             ebreak_i,
    input  logic [3:0]       rd_i,
    input  logic             speculation_i,
    output logic             rf_wen_o,
    output logic [3:0]       rf_waddr_o,
    output logic [BIT_W-1:0] rf_wdata_o,
    output logic             redirect_o,
    output logic [BIT_W-1:0] npc_o,
    output logic             retire_valid_o,
    output logic [BIT_W-1:0] retire_pc_o,
    output logic [31:0]      retire_inst_o,
    output logic             halt_o,
    output logic [63:0]      retire_cnt_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t state, state_n;

    logic [31:0]      q_inst [DEPTH];
    logic [BIT_W-1:0] q_pc   [DEPTH];
    logic [BIT_W-1:0] q_wd   [DEPTH];
    logic [BIT_W-1:0] q_npc  [DEPTH];
    logic             q_use  [DEPTH];
    logic             q_br   [DEPTH];
    logic             q_eb   [DEPTH];
    logic [3:0]       q_rd   [DEPTH];
    logic             q_spec [DEPTH];

    logic [PW-1:0] head, tail, head_n, tail_n, idx;
    logic [CW-1:0] count, count_n, sq_n, sq_eff;
    logic          squash_pending;
    logic          push, push_keep, pop, halt_pop, redir_pop, run;
    logic          unused_br;

    // branch_retire travels with the entry for trace purposes only
    assign unused_br = q_br[head];

    // Queue control: pop, squash extent, and next pointer/count values.
    // The squash drops the run of speculative entries directly behind the
    // popped head; speculative entries are always younger than
    // non-speculative ones, so this is every speculative entry queued.
    // An entry arriving on the same edge is dropped if it is speculative.
    always_comb begin
        push     = prev_valid & ready_o;
        pop      = (state == RUN) && (count != '0);
        halt_pop = pop & q_eb[head];
        redir_pop = pop & q_use[head];
        sq_n = '0;
        run  = 1'b1;
        idx  = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (run && (i < 32'(count)) && q_spec[idx]) sq_n = sq_n + CW'(1);
            else run = 1'b0;
        end
        sq_eff    = redir_pop ? sq_n : '0;
        push_keep = push & ~halt_pop & ~(redir_pop & speculation_i);
        if (halt_pop) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
        end else begin
            head_n  = head + PW'(pop) + sq_eff[PW-1:0];
            tail_n  = tail + PW'(push_keep);
            count_n = count - CW'(pop) - sq_eff + CW'(push_keep);
        end
    end

    // State register, queue pointers and the one-cycle squash flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            squash_pending <= 1'b0;
        end else begin
            state          <= state_n;
            head           <= head_n;
            tail           <= tail_n;
            count          <= count_n;
            squash_pending <= redir_pop;
        end
    end

    // Next-state: retiring an ebreak halts; HALT is left only by reset
    always_comb begin
        state_n = state;
        if (state == RUN && halt_pop) state_n = HALT;
    end

    // Outputs decoded from registered state only
    always_comb begin
        ready_o = (count < CW'(DEPTH)) && (state == RUN) && !squash_pending;
        halt_o  = (state == HALT);
    end

    // Queue storage; validity is tracked by count, so no reset needed
    always_ff @(posedge clk) begin
        if (push_keep) begin
            q_inst[tail] <= inst_i;
            q_pc[tail]   <= pc_i;
            q_wd[tail]   <= reg_wdata_i;
            q_npc[tail]  <= npc_wdata_i;
            q_use[tail]  <= use_exu_npc_i;
            q_br[tail]   <= branch_retire_i;
            q_eb[tail]   <= ebreak_i;
            q_rd[tail]   <= rd_i;
            q_spec[tail] <= speculation_i;
        end
    end

    // Registered retire outputs: strobes pulse on a pop, data holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_valid_o <= 1'b0;
            rf_wen_o       <= 1'b0;
            redirect_o     <= 1'b0;
            rf_waddr_o     <= '0;
            rf_wdata_o     <= '0;
            npc_o          <= '0;
            retire_pc_o    <= '0;
            retire_inst_o  <= '0;
            retire_cnt_o   <= '0;
        end else begin
            retire_valid_o <= pop;
            rf_wen_o       <= pop && (q_rd[head] != 4'd0);
            redirect_o     <= redir_pop;
            if (pop) begin
                rf_waddr_o    <= q_rd[head];
                rf_wdata_o    <= q_wd[head];
                npc_o         <= q_use[head] ? q_npc[head] : q_pc[head] + BIT_W'(4);
                retire_pc_o   <= q_pc[head];
                retire_inst_o <= q_inst[head];
                retire_cnt_o  <= retire_cnt_o + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_wbu.sv
// Scoreboard bench for ysyx_wbu: a queue-based reference model predicts each
// retire; a monitor compares DUT retires against the expected queue.
module tb_ysyx_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        prev_valid;
    logic        ready_o;
    logic [31:0] inst_i, pc_i, reg_wdata_i, npc_wdata_i;
    logic        use_exu_npc_i, branch_retire_i, ebreak_i, speculation_i;
    logic [3:0]  rd_i;
    logic        rf_wen_o, redirect_o, retire_valid_o, halt_o;
    logic [3:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o, npc_o, retire_pc_o, retire_inst_o;
    logic [63:0] retire_cnt_o;

    ysyx_wbu #(.BIT_W(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(ready_o),
        .inst_i(inst_i), .pc_i(pc_i), .reg_wdata_i(reg_wdata_i),
        .npc_wdata_i(npc_wdata_i), .use_exu_npc_i(use_exu_npc_i),
        .branch_retire_i(branch_retire_i), .ebreak_i(ebreak_i), .rd_i(rd_i),
        .speculation_i(speculation_i), .rf_wen_o(rf_wen_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .redirect_o(redirect_o), .npc_o(npc_o),
        .retire_valid_o(retire_valid_o), .retire_pc_o(retire_pc_o),
        .retire_inst_o(retire_inst_o), .halt_o(halt_o),
        .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst, pc, wd, npc;
        bit          use_npc, br, eb, spec;
        logic [3:0]  rd;
    } ent_t;

    typedef struct {
        logic [31:0] pc, inst, wdata, npc;
        logic [3:0]  waddr;
        bit          wen, redir;
        logic [63:0] cnt;
    } exp_t;

    ent_t  mq[$];
    exp_t  exp_q[$];
    bit    m_halt, m_sq;
    logic [63:0] m_cnt;
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_halt && (mq.size() < 2) && !m_sq;
    endfunction

    // Reference behaviour for one clock edge: retire oldest entry, apply
    // ebreak/redirect consequences, then accept the offered entry if allowed.
    task automatic model_edge(input bit v, input ent_t e);
        bit   acc, new_sq;
        ent_t h, keep[$];
        exp_t x;
        acc    = v && m_ready();
        new_sq = 0;
        if (!m_halt && mq.size() > 0) begin
            h = mq.pop_front();
            m_cnt   = m_cnt + 1;
            x.pc    = h.pc;
            x.inst  = h.inst;
            x.wen   = (h.rd != 0);
            x.waddr = h.rd;
            x.wdata = h.wd;
            x.npc   = h.use_npc ? h.npc : h.pc + 32'd4;
            x.redir = h.use_npc;
            x.cnt   = m_cnt;
            exp_q.push_back(x);
            if (h.eb) begin
                m_halt = 1;
                mq.delete();
                acc = 0;
            end else if (h.use_npc) begin
                new_sq = 1;
                foreach (mq[i]) if (!mq[i].spec) keep.push_back(mq[i]);
                mq = keep;
                if (e.spec) acc = 0;
            end
        end
        if (acc) mq.push_back(e);
        m_sq = new_sq;
    endtask

    // One cycle, entered and left at a negedge
    task automatic step(input bit v, input ent_t e);
        check("ready", ready_o, m_ready());
        check("halt", halt_o, m_halt);
        prev_valid      = v;
        inst_i          = e.inst;
        pc_i            = e.pc;
        reg_wdata_i     = e.wd;
        npc_wdata_i     = e.npc;
        use_exu_npc_i   = e.use_npc;
        branch_retire_i = e.br;
        ebreak_i        = e.eb;
        rd_i            = e.rd;
        speculation_i   = e.spec;
        model_edge(v, e);
        @(negedge clk);
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [3:0] rd,
                                input logic [31:0] wd, input bit use_npc,
                                input logic [31:0] npc, input bit eb, input bit spec);
        ent_t e;
        e.inst = $urandom; e.pc = pc; e.rd = rd; e.wd = wd; e.use_npc = use_npc;
        e.npc = npc; e.eb = eb; e.spec = spec; e.br = $urandom_range(0, 1);
        return e;
    endfunction

    function automatic ent_t rnd();
        logic [31:0] pc;
        logic [3:0]  rd;
        pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        rd = 4'($urandom);
        return mk(pc, rd, (rd == 0) ? 32'd0 : $urandom, $urandom_range(0, 3) == 0,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 1) == 1);
    endfunction

    // Asynchronous reset landing mid-cycle after an edge that may retire
    task automatic mid_reset();
        ent_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        prev_valid = 0;
        model_edge(0, idle);
        @(posedge clk);
        #3 rst = 1;
        #1;
        check("rst_valid", retire_valid_o, 0);
        check("rst_wen", rf_wen_o, 0);
        check("rst_redir", redirect_o, 0);
        check("rst_halt", halt_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_cnt", retire_cnt_o, 0);
        check("rst_npc", npc_o, 0);
        check("rst_data", {rf_wdata_o, retire_pc_o}, 0);
        @(negedge clk);
        rst = 0;
        mq.delete();
        exp_q.delete();
        m_halt = 0; m_sq = 0; m_cnt = 0;
    endtask

    // Monitor: compare every presented retire, and strobe quietness otherwise
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            if (retire_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", retire_pc_o, 0);
                    bad += (retire_pc_o == 0) ? 1 : 0;
                end else begin
                    x = exp_q.pop_front();
                    check("ret_pc", retire_pc_o, x.pc);
                    check("ret_inst", retire_inst_o, x.inst);
                    check("rf_wen", rf_wen_o, x.wen);
                    check("rf_waddr", rf_waddr_o, x.waddr);
                    check("rf_wdata", rf_wdata_o, x.wdata);
                    check("npc", npc_o, x.npc);
                    check("redirect", redirect_o, x.redir);
                    check("ret_cnt", retire_cnt_o, x.cnt);
                end
            end else begin
                check("idle_strobes", {rf_wen_o, redirect_o}, 0);
                if (exp_q.size() > 0) check("missing_retire", 0, 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        ent_t nop;
        rst = 1; prev_valid = 0;
        m_halt = 0; m_sq = 0; m_cnt = 0;
        nop = mk(0, 0, 0, 0, 0, 0, 0);
        inst_i = 0; pc_i = 0; reg_wdata_i = 0; npc_wdata_i = 0;
        use_exu_npc_i = 0; branch_retire_i = 0; ebreak_i = 0; rd_i = 0; speculation_i = 0;
        repeat (2) @(negedge clk);
        check("init_ready", ready_o, 1);
        check("init_valid", retire_valid_o, 0);
        check("init_cnt", retire_cnt_o, 0);
        rst = 0;

        // single ALU op
        step(1, mk(32'h8000_0000, 5, 32'h1234, 0, 0, 0, 0));
        step(0, nop);
        step(0, nop);
        // rd == 0
        step(1, mk(32'h8000_0008, 0, 0, 0, 0, 0, 0));
        step(0, nop);
        // four back-to-back
        for (int i = 0; i < 4; i++) step(1, mk(32'h8000_0020 + 4 * i, 4'(i + 1), $urandom, 0, 0, 0, 0));
        step(0, nop);
        step(0, nop);
        // jump then two speculative entries
        step(1, mk(32'h8000_0010, 1, 32'h8000_0014, 1, 32'h8000_0100, 0, 0));
        step(1, mk(32'h8000_0014, 2, 32'h22, 0, 0, 0, 1));
        step(1, mk(32'h8000_0018, 3, 32'h33, 0, 0, 0, 1));
        step(0, nop);
        step(0, nop);
        // redirect with a non-speculative entry behind it
        step(1, mk(32'h8000_0200, 0, 0, 1, 32'h8000_0300, 0, 0));
        step(1, mk(32'h8000_0300, 7, 32'h77, 0, 0, 0, 0));
        step(0, nop);
        step(0, nop);
        // pc+4 wraps to zero
        step(1, mk(32'hFFFF_FFFC, 9, 32'h99, 0, 0, 0, 0));
        step(0, nop);
        // ebreak with one entry following, then ignored traffic
        step(1, mk(32'h8000_0400, 0, 0, 0, 0, 1, 0));
        step(1, mk(32'h8000_0404, 6, 32'h66, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) step(1, rnd());
        mid_reset();
        step(0, nop);
        step(0, nop);
        // reset while draining
        step(1, rnd());
        mid_reset();
        step(0, nop);

        for (int i = 0; i < 3000; i++) begin
            if (m_halt && $urandom_range(0, 3) == 0) mid_reset();
            else step($urandom_range(0, 3) != 0, rnd());
        end
        for (int i = 0; i < 4; i++) step(0, nop);
        check("drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_wbu.md
Name: ysyx_wbu

Overview:
Write-back/retire stage directly downstream of the execute stage. It accepts one finished instruction per handshake into a 2-entry result queue and retires at most one entry per cycle. On retire it drives the register-file write port, the next-PC redirect and the retire trace. Retiring an ebreak halts the core. A taken redirect squashes any queued speculative entries.

Parameters:
BIT_W, `YSYX_W_WIDTH (32), datapath width
DEPTH, 2, result-queue entries (power of two, >= 2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
prev_valid  in  1  execute result valid
ready_o  out  1  queue can accept an entry
inst_i  in  32  instruction word
pc_i  in  BIT_W  instruction PC
reg_wdata_i  in  BIT_W  rd write data (already zero when rd==0)
npc_wdata_i  in  BIT_W  redirect target
use_exu_npc_i  in  1  take redirect target
branch_retire_i  in  1  control-flow/system/load instruction
ebreak_i  in  1  instruction is ebreak
rd_i  in  4  destination register
speculation_i  in  1  fetched under an unresolved prediction
rf_wen_o  out  1  register write strobe
rf_waddr_o  out  4  register write address
rf_wdata_o  out  BIT_W  register write data
redirect_o  out  1  one-cycle PC redirect pulse
npc_o  out  BIT_W  redirect target / next PC of retired instruction
retire_valid_o  out  1  one-cycle retire pulse
retire_pc_o  out  BIT_W  retired PC
retire_inst_o  out  32  retired instruction
halt_o  out  1  core halted by ebreak
retire_cnt_o  out  64  retired-instruction counter

Behaviour:
- Reset (async, any cycle, including mid-drain): queue empty, head/tail/count 0, state RUN. All outputs 0 except ready_o=1. Counter 0.
- Queue: circular, DEPTH entries; push when prev_valid & ready_o. Stored fields: inst, pc, reg_wdata, npc_wdata, use_exu_npc, branch_retire, ebreak, rd, speculation.
- ready_o = (count < DEPTH) & (state==RUN) & !squash_pending. Combinational from registered state only; no dependency on prev_valid.
- Push when full is impossible. Push and pop in the same cycle keep count unchanged; pointers wrap modulo DEPTH.
- Latency: entry pushed at edge N is eligible to pop at edge N+1. Retire outputs are registered and valid in the cycle after the pop edge.
- FSM states:
  - RUN, count>0: pop head every cycle.
    - retire_valid_o=1, retire_pc_o/retire_inst_o = head fields, retire_cnt_o+1.
    - rf_wen_o = (rd!=0), rf_waddr_o=rd, rf_wdata_o=reg_wdata.
    - npc_o = use_exu_npc ? npc_wdata : pc+4, truncated to BIT_W; wrap at 0xFFFFFFFC+4 gives 0.
    - redirect_o = use_exu_npc.
  - Redirect squash: if the popped entry has use_exu_npc=1, every remaining queued entry with speculation=1 is discarded in the same edge. Count drops accordingly and the head advances past them. Non-speculative entries remain.
    - squash_pending=1 for exactly that cycle, deasserting ready_o.
  - Popped entry with ebreak=1: retire it normally, including the rd write, then enter HALT. Remaining entries are discarded.
  - HALT: halt_o=1, ready_o=0, no further retire. Leaves only by reset.
- All strobes (rf_wen_o, redirect_o, retire_valid_o) are single-cycle pulses; they are 0 in any cycle with no pop. Data outputs hold their last value.
- branch_retire is carried for trace use only; it has no effect on control.
- retire_cnt_o wraps silently at 2^64.

Test Plan:
- Single ALU op: pc=0x80000000, rd=5, data=0x1234, no redirect -> next cycle rf_wen_o=1, waddr=5, wdata=0x1234, npc_o=0x80000004, redirect_o=0, retire_cnt_o=1.
- rd=0 instruction -> rf_wen_o=0 and retire_valid_o=1. Back-to-back 4 pushes with continuous pops -> ready_o stays 1, 4 retires on consecutive cycles.
- Jump pc=0x80000010, npc=0x80000100 followed by two speculative entries queued -> redirect_o=1, npc_o=0x80000100, both speculative entries never retire, retire_cnt_o+1 only, ready_o=0 for one cycle.
- Redirect with a non-speculative entry behind it -> that entry retires on the next cycle with its own npc.
- ebreak with rd=0 followed by one queued entry -> ebreak retires, halt_o=1 from the next cycle, the queued entry is dropped, ready_o=0 thereafter, prev_valid ignored.
- Assert rst asynchronously mid-cycle with queue full -> outputs clear immediately, ready_o=1, retire_cnt_o=0, no retire after deassertion until new push.
